// File: rtl/x25519_field_unit_if.sv
// Signal bundle for x25519_field_unit: field add, field multiply and constant-time swap.
// The design side uses modport slave and the driver side uses modport master.
interface x25519_field_unit_if;
    logic         add_en;
    logic [263:0] add_a;
    logic [263:0] add_b;
    logic         add_valid;
    logic [263:0] add_out;

    logic         mult_en;
    logic [263:0] mult_a;
    logic [263:0] mult_b;
    logic         mult_busy;
    logic         mult_valid;
    logic [263:0] mult_out;

    logic         select_en;
    logic [511:0] sel_r;
    logic [511:0] sel_s;
    logic         sel_b;
    logic         select_valid;
    logic [511:0] sel_p;
    logic [511:0] sel_q;

    modport slave (
        input  add_en, add_a, add_b, mult_en, mult_a, mult_b,
               select_en, sel_r, sel_s, sel_b,
        output add_valid, add_out, mult_busy, mult_valid, mult_out,
               select_valid, sel_p, sel_q
    );

    modport master (
        output add_en, add_a, add_b, mult_en, mult_a, mult_b,
               select_en, sel_r, sel_s, sel_b,
        input  add_valid, add_out, mult_busy, mult_valid, mult_out,
               select_valid, sel_p, sel_q
    );
endinterface

// File: rtl/x25519_field_unit.sv
// GF(2^255-19) unit: 2-stage pipelined add, 16-digit serial multiply (18 cycles), masked swap.
// Define X25519_FULL_REDUCE_EN to fully reduce add/mult results into [0, p-1].
module x25519_field_unit (
    input logic                clk,
    input logic                rst,
    x25519_field_unit_if.slave bus
);

    function automatic logic [255:0] final_sub(input logic [255:0] t);
`ifdef X25519_FULL_REDUCE_EN
        localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};
        final_sub = (t >= P) ? t - P : t;
`else
        final_sub = t;
`endif
    endfunction

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_FINAL, M_DONE} mult_state_e;

    // Add pipeline
    logic [256:0] add_sum_q, add_sum_d;
    logic         add_v1_q;
    logic [255:0] add_fold;
    logic [255:0] add_out_q, add_out_d;
    logic         add_valid_q;

    // Select
    logic [511:0] swap_mask, swap_diff;
    logic [511:0] sel_p_q, sel_p_d, sel_q_q, sel_q_d;
    logic         sel_valid_q;

    // Multiplier
    mult_state_e  state_q, state_d;
    logic [255:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [255:0] mult_out_q, mult_out_d;
    logic [271:0] mul_prod;
    logic [272:0] mul_sum;
    logic [255:0] mul_iter, mul_fin_fold;

    logic unused_hi;
    assign unused_hi = ^{bus.add_a[263:256], bus.add_b[263:256],
                         bus.mult_a[263:256], bus.mult_b[263:256]};

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        add_sum_d = {1'b0, bus.add_a[255:0]} + {1'b0, bus.add_b[255:0]};
        // 2^255 == 19 (mod p): fold the two top sum bits back into the low end.
        add_fold  = {1'b0, add_sum_q[254:0]} + 256'(add_sum_q[256:255]) * 256'd19;
        add_out_d = add_v1_q ? final_sub(add_fold) : add_out_q;
    end

    always_comb begin
        swap_mask = {512{bus.sel_b}};
        swap_diff = (bus.sel_r ^ bus.sel_s) & swap_mask;
        sel_p_d   = bus.select_en ? (bus.sel_r ^ swap_diff) : sel_p_q;
        sel_q_d   = bus.select_en ? (bus.sel_s ^ swap_diff) : sel_q_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_sum_q   <= '0;
            add_v1_q    <= 1'b0;
            add_out_q   <= '0;
            add_valid_q <= 1'b0;
            sel_p_q     <= '0;
            sel_q_q     <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            add_sum_q   <= add_sum_d;
            add_v1_q    <= bus.add_en;
            add_out_q   <= add_out_d;
            add_valid_q <= add_v1_q;
            sel_p_q     <= sel_p_d;
            sel_q_q     <= sel_q_d;
            sel_valid_q <= bus.select_en;
        end
    end

    // acc < 2^256 is kept: the 273-bit step sum folds at 2^255 to below 2^255 + 19*2^18.
    always_comb begin
        mul_prod     = 272'(mul_a_q) * 272'(mul_b_q[255:240]);
        mul_sum      = {1'b0, acc_q, 16'h0000} + {1'b0, mul_prod};
        mul_iter     = 256'(mul_sum[254:0]) + 256'(mul_sum[272:255]) * 256'd19;
        mul_fin_fold = 256'(acc_q[254:0]) + 256'(acc_q[255]) * 256'd19;
    end

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mult_out_d = mult_out_q;
        case (state_q)
            M_IDLE: begin
                if (bus.mult_en) begin
                    mul_a_d = bus.mult_a[255:0];
                    mul_b_d = bus.mult_b[255:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = M_RUN;
                end
            end
            M_RUN: begin
                acc_d   = mul_iter;
                mul_b_d = {mul_b_q[239:0], 16'h0000};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = M_FINAL;
                end
            end
            M_FINAL: begin
                mult_out_d = final_sub(mul_fin_fold);
                state_d    = M_DONE;
            end
            M_DONE: begin
                state_d = M_IDLE;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= M_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: operand and accumulator registers are reset too, so an aborted multiply leaves no stale state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mult_out_q <= '0;
        end else begin
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mult_out_q <= mult_out_d;
        end
    end

    assign bus.add_out      = {8'h00, add_out_q};
    assign bus.add_valid    = add_valid_q;
    assign bus.mult_out     = {8'h00, mult_out_q};
    assign bus.mult_valid   = (state_q == M_DONE);
    assign bus.mult_busy    = (state_q != M_IDLE);
    assign bus.sel_p        = sel_p_q;
    assign bus.sel_q        = sel_q_q;
    assign bus.select_valid = sel_valid_q;

endmodule

// File: tb/tb_x25519_field_unit.sv
// Self-checking bench for x25519_field_unit; results are compared modulo p against a
// big-integer reference, so the bench holds with or without full final reduction.
module tb_x25519_field_unit;

    localparam logic [511:0] P512 = (512'd1 << 255) - 512'd19;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    x25519_field_unit_if bus();

    x25519_field_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rnd256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [255:0] fe_mod(input logic [511:0] x);
        logic [511:0] r;
        r = x % P512;
        return r[255:0];
    endfunction

    function automatic logic [255:0] add_ref(input logic [255:0] a, input logic [255:0] b);
        return fe_mod(512'(a) + 512'(b));
    endfunction

    function automatic logic [255:0] mul_ref(input logic [255:0] a, input logic [255:0] b);
        return fe_mod(512'(a) * 512'(b));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A field output must have zero guard bits and be congruent to the expected residue.
    task automatic check_fe(input string tag, input logic [263:0] obs, input logic [255:0] exp);
        logic [511:0] n;
        n = 512'(obs);
        if (obs[263:256] == 8'h00) n = n % P512;
        check(tag, n, 512'(exp));
    endtask

    task automatic run_mult(input string tag, input logic [255:0] a, input logic [255:0] b,
                            input logic [255:0] exp, input int ghost_at);
        int           pulses;
        int           pulse_cycle;
        int           busy_low;
        logic [263:0] obs;
        pulses = 0; pulse_cycle = 0; busy_low = 0; obs = '0;
        bus.mult_a  = {8'h00, a};
        bus.mult_b  = {8'h00, b};
        bus.mult_en = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus.mult_en = (c == ghost_at);
            if (c == ghost_at) begin
                bus.mult_a = {8'h00, rnd256()};
                bus.mult_b = {8'h00, rnd256()};
            end
            if (bus.mult_valid) begin
                pulses++;
                pulse_cycle = c;
            end
            if (!bus.mult_busy) busy_low++;
            if (c == 18) obs = bus.mult_out;
        end
        tick();
        bus.mult_en = 1'b0;
        check({tag, " pulses"}, 512'(pulses), 512'd1);
        check({tag, " latency"}, 512'(pulse_cycle), 512'd18);
        check({tag, " busy held"}, 512'(busy_low), 512'd0);
        check_fe({tag, " value"}, obs, exp);
        check({tag, " busy drop"}, 512'(bus.mult_busy), 512'd0);
        check_fe({tag, " hold"}, bus.mult_out, exp);
        if (ghost_at != 0) begin
            pulses = 0;
            for (int c = 0; c < 24; c++) begin
                tick();
                if (bus.mult_valid || bus.mult_busy) pulses++;
            end
            check({tag, " ghost ignored"}, 512'(pulses), 512'd0);
        end
    endtask

    logic [255:0] p256, pm1, t128, ones, ra, rb, last_add;
    logic [511:0] sa, sb, exp_p, exp_q;
    logic [255:0] ea[6];
    logic [255:0] eb[6];
    logic [255:0] add_q[$];
    int           en_hist[25];
    int           pulses, busy_hi, exp_v;

    initial begin
        p256 = P512[255:0];
        pm1  = p256 - 256'd1;
        t128 = '0;
        t128[128] = 1'b1;
        ones = '1;

        rst = 1'b1;
        bus.add_en = 1'b0;    bus.add_a = '0;  bus.add_b = '0;
        bus.mult_en = 1'b0;   bus.mult_a = '0; bus.mult_b = '0;
        bus.select_en = 1'b0; bus.sel_r = '0;  bus.sel_s = '0; bus.sel_b = 1'b0;
        tick();
        tick();
        check("reset add_out", 512'(bus.add_out), 512'd0);
        check("reset mult_out", 512'(bus.mult_out), 512'd0);
        check("reset busy", 512'(bus.mult_busy), 512'd0);
        check("reset sel_p", bus.sel_p, 512'd0);
        check("reset valids", 512'({bus.add_valid, bus.mult_valid, bus.select_valid}), 512'd0);

        // All three strobes on the first edge after reset release.
        rst = 1'b0;
        sa = {rnd256(), rnd256()};
        sb = {rnd256(), rnd256()};
        bus.add_a = {8'h00, pm1};  bus.add_b = {8'h00, 256'd1}; bus.add_en = 1'b1;
        bus.mult_a = {8'h00, pm1}; bus.mult_b = {8'h00, pm1};   bus.mult_en = 1'b1;
        bus.sel_r = sa; bus.sel_s = sb; bus.sel_b = 1'b1;       bus.select_en = 1'b1;
        tick();
        bus.add_en = 1'b0; bus.mult_en = 1'b0; bus.select_en = 1'b0;
        check("sim select_valid", 512'(bus.select_valid), 512'd1);
        check("sim sel_p swapped", bus.sel_p, sb);
        check("sim sel_q swapped", bus.sel_q, sa);
        check("sim add early", 512'(bus.add_valid), 512'd0);
        check("sim busy", 512'(bus.mult_busy), 512'd1);
        tick();
        check("sim add_valid", 512'(bus.add_valid), 512'd1);
        check_fe("sim add p-1+1", bus.add_out, 256'd0);
        check("sim select pulse", 512'(bus.select_valid), 512'd0);
        pulses = 0;
        for (int c = 3; c <= 17; c++) begin
            tick();
            if (bus.mult_valid) pulses++;
        end
        tick();
        check("sim mult early", 512'(pulses), 512'd0);
        check("sim mult_valid", 512'(bus.mult_valid), 512'd1);
        check_fe("sim mult (p-1)^2", bus.mult_out, 256'd1);
        tick();
        check("sim mult idle", 512'({bus.mult_valid, bus.mult_busy}), 512'd0);

        // Add pipeline: edge operands then random, back-to-back first, then with gaps.
        ea[0] = pm1;                          eb[0] = 256'd1;
        ea[1] = (256'd1 << 255) - 256'd20;    eb[1] = 256'd5;
        ea[2] = ones;                         eb[2] = ones;
        ea[3] = p256;                         eb[3] = p256;
        ea[4] = p256;                         eb[4] = 256'd0;
        ea[5] = 256'd0;                       eb[5] = 256'd0;
        en_hist[24] = 0;
        last_add = '0;
        for (int c = 0; c < 26; c++) begin
            if (c < 24) begin
                en_hist[c] = (c < 10) ? 1 : int'($urandom_range(3, 0) != 0);
                ra = (c < 6) ? ea[c] : rnd256();
                rb = (c < 6) ? eb[c] : rnd256();
                bus.add_a  = {8'h00, ra};
                bus.add_b  = {8'h00, rb};
                bus.add_en = (en_hist[c] != 0);
                if (en_hist[c] != 0) add_q.push_back(add_ref(ra, rb));
            end else begin
                bus.add_en = 1'b0;
            end
            tick();
            exp_v = (c >= 1) ? en_hist[c-1] : 0;
            check("add valid timing", 512'(bus.add_valid), 512'(exp_v != 0));
            if (exp_v != 0 && add_q.size() > 0) begin
                last_add = add_q.pop_front();
                check_fe("add value", bus.add_out, last_add);
            end
        end
        tick();
        check_fe("add hold", bus.add_out, last_add);
        check("add no stray", 512'(bus.add_valid), 512'd0);

        // Back-to-back selects, then hold with select_en low.
        for (int i = 0; i < 6; i++) begin
            sa = {rnd256(), rnd256()};
            sb = {rnd256(), rnd256()};
            bus.sel_r = sa; bus.sel_s = sb; bus.sel_b = (i % 2 == 0) ? 1'b0 : 1'b1;
            bus.select_en = 1'b1;
            exp_p = bus.sel_b ? sb : sa;
            exp_q = bus.sel_b ? sa : sb;
            tick();
            check("sel valid", 512'(bus.select_valid), 512'd1);
            check("sel_p", bus.sel_p, exp_p);
            check("sel_q", bus.sel_q, exp_q);
        end
        bus.select_en = 1'b0;
        bus.sel_r = {rnd256(), rnd256()};
        bus.sel_s = {rnd256(), rnd256()};
        bus.sel_b = 1'b1;
        tick();
        tick();
        check("sel hold valid", 512'(bus.select_valid), 512'd0);
        check("sel_p hold", bus.sel_p, exp_p);
        check("sel_q hold", bus.sel_q, exp_q);

        // Multiplier directed and random cases, including ignored strobes while busy.
        run_mult("mult 2^128 sq", t128, t128, 256'd38, 5);
        run_mult("mult 121665*2", 256'd121665, 256'd2, 256'd243330, 18);
        run_mult("mult max sq", ones, ones, mul_ref(ones, ones), 0);
        ra = rnd256();
        run_mult("mult p*r", p256, ra, 256'd0, 0);
        for (int i = 0; i < 3; i++) begin
            ra = rnd256();
            rb = rnd256();
            run_mult("mult random", ra, rb, mul_ref(ra, rb), 0);
        end

        // Abort: reset 10 cycles into a multiply with an add and a select in flight.
        bus.mult_a = {8'h00, rnd256()}; bus.mult_b = {8'h00, rnd256()}; bus.mult_en = 1'b1;
        tick();
        bus.mult_en = 1'b0;
        repeat (8) tick();
        bus.add_a = {8'h00, rnd256()}; bus.add_b = {8'h00, rnd256()}; bus.add_en = 1'b1;
        bus.select_en = 1'b1;
        tick();
        bus.add_en = 1'b0; bus.select_en = 1'b0;
        rst = 1'b1;
        #1;
        check("abort add_out", 512'(bus.add_out), 512'd0);
        check("abort mult_out", 512'(bus.mult_out), 512'd0);
        check("abort busy", 512'(bus.mult_busy), 512'd0);
        check("abort sel_p", bus.sel_p, 512'd0);
        check("abort sel_q", bus.sel_q, 512'd0);
        check("abort valids", 512'({bus.add_valid, bus.mult_valid, bus.select_valid}), 512'd0);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        busy_hi = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.add_valid || bus.mult_valid || bus.select_valid) pulses++;
            if (bus.mult_busy) busy_hi++;
        end
        check("abort no valid", 512'(pulses), 512'd0);
        check("abort stays idle", 512'(busy_hi), 512'd0);
        ra = rnd256();
        rb = rnd256();
        run_mult("mult after abort", ra, rb, mul_ref(ra, rb), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x25519_field_unit.md
X25519_FIELD_UNIT -- requirements
Module: x25519_field_unit

Interface
REQ-001 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports add_en in 1 strobe; add_a, add_b in 264 operands; add_valid out 1 pulse; add_out out 264 sum.
REQ-004 SHALL have ports mult_en in 1 strobe; mult_a, mult_b in 264 operands; mult_busy out 1; mult_valid out 1 pulse; mult_out out 264 product.
REQ-005 SHALL have ports select_en in 1 strobe; sel_r, sel_s in 512 point pairs (X low 256, Z high 256); sel_b in 1 swap bit; select_valid out 1 pulse; sel_p, sel_q out 512.
REQ-006 SHALL define operands as integers in bits [255:0] with bits [263:256] zero; p = 2^255-19.

Function
REQ-007 Add SHALL output (add_a + add_b) mod p, bits [263:256] zero, add_valid high exactly 2 cycles after add_en sampled high.
REQ-008 Add SHALL be fully pipelined: one new operation per cycle, back-to-back strobes yield back-to-back valids in order.
REQ-009 Mult SHALL output (mult_a * mult_b) mod p, bits [263:256] zero, mult_valid high for 1 cycle exactly 18 cycles after accepted mult_en.
REQ-010 Mult SHALL be iterative: operands captured at mult_en; 16 iterations over mult_b 16-bit digits, MSB digit first, acc = (acc*2^16 + mult_a*digit) partially reduced mod p; final reduction cycle.
REQ-011 mult_busy SHALL be high from cycle after accepted mult_en through cycle mult_valid is high; mult_en while mult_busy SHALL be ignored (no capture, no extra valid).
REQ-012 mult_out SHALL hold last result until next result; add_out likewise.
REQ-013 Select SHALL register outputs 1 cycle after select_en: sel_b=0 -> sel_p=sel_r, sel_q=sel_s; sel_b=1 -> sel_p=sel_s, sel_q=sel_r; select_valid pulses same cycle.
REQ-014 Select SHALL be constant-time: swap via masked XOR, no data-dependent control flow; latency independent of sel_b.
REQ-015 Mult, add, select SHALL be independent; simultaneous strobes on all three SHALL all complete at their own latencies.
REQ-016 Inputs equal to or above p (up to 2^256-1) SHALL be accepted and reduced correctly.
REQ-017 sel_p/sel_q SHALL hold when select_en low.

Reset
REQ-018 rst high SHALL asynchronously clear all outputs to 0, mult_busy to 0, pipeline and iteration state to idle.
REQ-019 rst asserted mid-operation SHALL abort all in-flight operations; no valid pulse for them after release.
REQ-020 First strobe SHALL be accepted on first rising edge after rst deasserts.

Configuration
REQ-021 With macro X25519_FULL_REDUCE_EN defined, add_out and mult_out SHALL be fully reduced into [0, p-1].
REQ-022 Without X25519_FULL_REDUCE_EN, outputs SHALL be < 2^256 and congruent mod p (final conditional subtract of p omitted); latencies unchanged.

Verification (X25519_FULL_REDUCE_EN defined)
REQ-023 add_a=p-1, add_b=1 -> add_out=0 at +2 cycles; add_a=2^255-20, add_b=5 -> 4.
REQ-024 mult_a=mult_b=p-1 -> mult_out=1 at +18 cycles; mult_a=mult_b=2^128 -> 38; mult_a=121665, mult_b=2 -> 243330.
REQ-025 mult_en pulsed again 5 cycles after first -> ignored; single mult_valid at +18 with first result.
REQ-026 sel_r=A, sel_s=B, sel_b=1 -> sel_p=B, sel_q=A at +1; sel_b=0 -> sel_p=A, sel_q=B.
REQ-027 rst asserted 10 cycles into mult and during add pipeline -> outputs 0, no valid pulses; new mult after release returns correct result at +18.
REQ-028 add_en, mult_en, select_en same cycle -> valids at +2, +18, +1 with correct values.
